fma_norm_round: RTL and testbench

- Normalization and rounding stage of the single-precision FMA pipeline.
- Sits directly downstream of the stage-4 pipeline register. It consumes the raw adder result (carry, 50-bit significand sum, effective-op/sign flags, and the C and P exponents).
- Produces the final IEEE-754 binary32 result through a 2-deep internal pipeline with a valid/ready handshake.
- Mode is round-to-nearest-even, with denormals flushed to zero.

---
 rtl/fma_norm_round.sv | 143 ++++++++++++++
 tb/tb_fma_norm_round.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_norm_round.sv
// Normalize/round stage of the binary32 FMA: leading-one detect and shift (stage A),
// then round-to-nearest-even, overflow/underflow handling and packing (stage B).
module fma_norm_round #(
   parameter int SIG_W = 50,
   parameter int EXP_W = 8,
   parameter int BIAS  = 127
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             Cout_in,
   input  logic [SIG_W-1:0] sig_in,
   input  logic [1:0]       sub_en_in,
   input  logic [EXP_W-1:0] exp_C_in,
   input  logic [EXP_W-1:0] exp_P_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic [2:0]       flags
);
   localparam int M_W   = SIG_W + 1;
   localparam int IDX_W = $clog2(M_W);
   localparam int ET_W  = 11;
   localparam int MAN_W = 24;
   localparam int GRD   = M_W - MAN_W - 1;
   localparam logic signed [ET_W-1:0] HIDDEN_POS = ET_W'(SIG_W - 2);
   localparam logic signed [ET_W-1:0] EXP_MAX    = ET_W'(2 * BIAS + 1);
   localparam logic signed [ET_W-1:0] EXP_ZERO   = ET_W'(0);

   logic adv;
   logic out_valid_reg;
   logic [31:0] result_reg;
   logic [2:0] flags_reg;

   assign adv       = out_ready | ~out_valid_reg;
   assign in_ready  = adv;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign flags     = flags_reg;

   // ---------------- stage A: leading-one detect and normalize ----------------
   logic [M_W-1:0] m_in;
   logic [M_W-1:0] m_norm;
   logic [IDX_W-1:0] lead_pos;
   logic [EXP_W-1:0] e_max;
   logic signed [ET_W-1:0] etmp_next;

   assign m_in  = {Cout_in, sig_in};
   assign e_max = (exp_P_in > exp_C_in) ? exp_P_in : exp_C_in;

   always_comb begin
      lead_pos = '0;
      for (int i = 0; i < M_W; i++) begin
         if (m_in[i]) lead_pos = IDX_W'(i);
      end
   end

   assign m_norm    = m_in << (IDX_W'(M_W - 1) - lead_pos);
   // Biased exponent of the normalized value; the hidden one sits at bit SIG_W-2 of the sum.
   assign etmp_next = $signed({{(ET_W-EXP_W){1'b0}}, e_max})
                    + $signed({{(ET_W-IDX_W){1'b0}}, lead_pos}) - HIDDEN_POS;

   logic a_valid_reg;
   logic [M_W-1:0] a_m_reg;
   logic signed [ET_W-1:0] a_etmp_reg;
   logic a_sign_reg;
   logic a_sub_reg;
   logic a_zero_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid_reg <= 1'b0;
         a_m_reg     <= '0;
         a_etmp_reg  <= '0;
         a_sign_reg  <= 1'b0;
         a_sub_reg   <= 1'b0;
         a_zero_reg  <= 1'b0;
      end else if (adv) begin
         a_valid_reg <= in_valid;
         if (in_valid) begin
            a_m_reg    <= m_norm;
            a_etmp_reg <= etmp_next;
            a_sign_reg <= sub_en_in[1];
            a_sub_reg  <= sub_en_in[0];
            a_zero_reg <= (m_in == '0);
         end
      end
   end

   // ---------------- stage B: round-to-nearest-even and pack ----------------
   logic [MAN_W-1:0] mant;
   logic guard;
   logic sticky;
   logic round_up;
   logic rnd_carry;
   logic [MAN_W:0] mant_rnd;
   logic [MAN_W-2:0] frac;
   logic signed [ET_W-1:0] etmp_rnd;
   logic [31:0] result_next;
   logic [2:0] flags_next;

   assign mant      = a_m_reg[M_W-1 -: MAN_W];
   assign guard     = a_m_reg[GRD];
   assign sticky    = |a_m_reg[GRD-1:0];
   assign round_up  = guard & (sticky | mant[0]);
   assign mant_rnd  = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
   assign rnd_carry = mant_rnd[MAN_W];
   // A carry out means the mantissa became exactly 2.0, so the fraction is all zeros.
   assign frac      = rnd_carry ? mant_rnd[MAN_W-1:1] : mant_rnd[MAN_W-2:0];
   assign etmp_rnd  = a_etmp_reg + $signed({{(ET_W-1){1'b0}}, rnd_carry});

   always_comb begin
      result_next = {a_sign_reg, 31'b0};
      flags_next  = 3'b000;
      if (a_zero_reg) begin
         result_next = {a_sub_reg ? 1'b0 : a_sign_reg, 31'b0};
      end else if (etmp_rnd >= EXP_MAX) begin
         result_next = {a_sign_reg, {EXP_W{1'b1}}, 23'b0};
         flags_next  = 3'b101;
      end else if (etmp_rnd <= EXP_ZERO) begin
         // Flush to zero; the value is nonzero here, so it is always inexact.
         flags_next  = 3'b011;
      end else begin
         result_next = {a_sign_reg, etmp_rnd[EXP_W-1:0], frac};
         flags_next  = {2'b00, guard | sticky};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         flags_reg     <= '0;
      end else if (adv) begin
         out_valid_reg <= a_valid_reg;
         if (a_valid_reg) begin
            result_reg <= result_next;
            flags_reg  <= flags_next;
         end
      end
   end
endmodule

// File: tb/tb_fma_norm_round.sv
// Table-driven bench for fma_norm_round with an in-order scoreboard, stall and mid-flight reset sequences.
module tb_fma_norm_round;
   logic clk;
   logic rst;
   logic in_valid;
   logic in_ready;
   logic Cout_in;
   logic [49:0] sig_in;
   logic [1:0] sub_en_in;
   logic [7:0] exp_C_in;
   logic [7:0] exp_P_in;
   logic out_valid;
   logic out_ready;
   logic [31:0] result;
   logic [2:0] flags;

   typedef struct {
      logic        cout;
      logic [49:0] sig;
      logic [1:0]  sub;
      logic [7:0]  ec;
      logic [7:0]  ep;
      logic [31:0] res;
      logic [2:0]  flg;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic [2:0]  flg;
      int          acc;
      bit          lat;
   } sb_t;

   vec_t vt[20];
   sb_t  q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   fma_norm_round #(.SIG_W(50), .EXP_W(8), .BIAS(127)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .Cout_in(Cout_in), .sig_in(sig_in), .sub_en_in(sub_en_in),
      .exp_C_in(exp_C_in), .exp_P_in(exp_P_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input logic c, input logic [49:0] s, input logic [1:0] sb,
                               input logic [7:0] ec, input logic [7:0] ep,
                               input logic [31:0] r, input logic [2:0] f);
      vec_t v;
      v.cout = c; v.sig = s; v.sub = sb; v.ec = ec; v.ep = ep; v.res = r; v.flg = f;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Present vector i until accepted; the expectation is queued at the accepting edge.
   task automatic send(input int i, input bit lat);
      bit acc = 0;
      int tries = 0;
      sb_t e;
      @(negedge clk);
      in_valid  = 1'b1;
      Cout_in   = vt[i].cout;
      sig_in    = vt[i].sig;
      sub_en_in = vt[i].sub;
      exp_C_in  = vt[i].ec;
      exp_P_in  = vt[i].ep;
      while (!acc && tries < 50) begin
         #1;
         if (in_ready) begin
            acc   = 1;
            e.idx = i; e.res = vt[i].res; e.flg = vt[i].flg; e.acc = cyc; e.lat = lat;
            q.push_back(e);
         end
         @(posedge clk);
         if (!acc) begin
            @(negedge clk);
            tries++;
         end
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout[%0d]: got in_ready=0 expected 1", i);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #3;
      chk("drain_left", q.size(), 0);
      chk("idle_out_valid", 32'(out_valid), 0);
   endtask

   // Monitor: a transfer happens at the next rising edge when out_valid & out_ready.
   initial begin
      sb_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_output: got %h expected none", result);
            end else begin
               e = q.pop_front();
               chk($sformatf("result[%0d]", e.idx), result, e.res);
               chk($sformatf("flags[%0d]", e.idx), 32'(flags), 32'(e.flg));
               if (e.lat) chk($sformatf("latency[%0d]", e.idx), cyc - e.acc, 2);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      //            cout  sig                     sub    ec      ep      result          flags
      vt[0]  = mk(1'b0, 50'h1000000000000,  2'b00, 8'd100, 8'd127, 32'h3F800000, 3'b000);
      vt[1]  = mk(1'b1, 50'h0,              2'b00, 8'd127, 8'd3,   32'h40800000, 3'b000);
      vt[2]  = mk(1'b0, 50'h1,              2'b01, 8'd127, 8'd127, 32'h27800000, 3'b000);
      vt[3]  = mk(1'b0, 50'h0,              2'b11, 8'd127, 8'd127, 32'h00000000, 3'b000);
      vt[4]  = mk(1'b0, 50'h0,              2'b10, 8'd5,   8'd9,   32'h80000000, 3'b000);
      vt[5]  = mk(1'b1, 50'hC000000,        2'b00, 8'd127, 8'd0,   32'h40800002, 3'b001);
      vt[6]  = mk(1'b1, 50'h14000000,       2'b00, 8'd0,   8'd127, 32'h40800002, 3'b001);
      vt[7]  = mk(1'b1, 50'h3FFFFFC000000,  2'b00, 8'd127, 8'd127, 32'h41000000, 3'b001);
      vt[8]  = mk(1'b1, 50'h3FFFFFC000000,  2'b00, 8'd254, 8'd10,  32'h7F800000, 3'b101);
      vt[9]  = mk(1'b0, 50'h10000000000,    2'b00, 8'd1,   8'd0,   32'h00000000, 3'b011);
      vt[10] = mk(1'b0, 50'h1000000000000,  2'b10, 8'd127, 8'd127, 32'hBF800000, 3'b000);
      vt[11] = mk(1'b1, 50'h4000001,        2'b00, 8'd127, 8'd127, 32'h40800001, 3'b001);
      vt[12] = mk(1'b1, 50'h1,              2'b00, 8'd127, 8'd127, 32'h40800000, 3'b001);
      vt[13] = mk(1'b0, 50'h1000000000000,  2'b00, 8'd255, 8'd0,   32'h7F800000, 3'b101);
      vt[14] = mk(1'b0, 50'h1000000000000,  2'b00, 8'd254, 8'd0,   32'h7F000000, 3'b000);
      vt[15] = mk(1'b0, 50'h1000000000000,  2'b00, 8'd0,   8'd1,   32'h00800000, 3'b000);
      vt[16] = mk(1'b0, 50'h1000000000000,  2'b00, 8'd0,   8'd0,   32'h00000000, 3'b011);
      vt[17] = mk(1'b1, 50'h3FFFFFC000000,  2'b10, 8'd254, 8'd10,  32'hFF800000, 3'b101);
      vt[18] = mk(1'b0, 50'h10000000000,    2'b10, 8'd1,   8'd0,   32'h80000000, 3'b011);
      vt[19] = mk(1'b0, 50'h30000000000,    2'b01, 8'd130, 8'd2,   32'h3DC00000, 3'b000);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      Cout_in = 1'b0; sig_in = '0; sub_en_in = '0; exp_C_in = '0; exp_P_in = '0;
      repeat (3) @(negedge clk);
      #3;
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_result", result, 0);
      chk("reset_flags", 32'(flags), 0);
      chk("reset_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back stream of the whole table, no stalls.
      for (int i = 0; i < 20; i++) send(i, 1'b1);
      idle();
      drain();
      chk("hold_result_a", result, vt[19].res);

      // Bubbles between inputs.
      for (int i = 5; i < 10; i++) begin
         send(i, 1'b1);
         idle();
      end
      drain();
      chk("hold_result_b", result, vt[9].res);

      // Four back-to-back inputs with out_ready low for three cycles.
      fork
         begin
            send(0, 1'b0);
            send(1, 1'b0);
            send(2, 1'b0);
            send(5, 1'b0);
            idle();
         end
         begin
            for (int n = 0; n < 8; n++) begin
               @(negedge clk);
               out_ready = !(n >= 3 && n < 6);
               #2;
               if (n >= 3 && n < 6) begin
                  chk($sformatf("stall_out_valid[%0d]", n), 32'(out_valid), 1);
                  chk($sformatf("stall_in_ready[%0d]", n), 32'(in_ready), 0);
               end
            end
         end
      join
      drain();

      // Reset with two results in flight.
      out_ready = 1'b0;
      send(0, 1'b0);
      send(1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      chk("pre_rst_out_valid", 32'(out_valid), 1);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result", result, 0);
      chk("rst_flags", 32'(flags), 0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #3;
      chk("post_rst_out_valid", 32'(out_valid), 0);
      out_ready = 1'b1;
      send(10, 1'b1);
      idle();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
